// File: rtl/stream_demux2.sv
// Two-way stream demultiplexer: each input beat is routed by in_sel into one of
// two independent 2-entry FIFOs, each with its own delivered-beat counter.
module stream_demux2 #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic [WIDTH-1:0] mem [2][2];
  logic [1:0]       occ [2];
  logic [CNTW-1:0]  cnt [2];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [1:0]       push;
  logic [1:0]       pop;

  // Acceptance looks only at the selected FIFO's occupancy, never at downstream ready.
  assign in_ready = !reset && (occ[in_sel] < 2'd2);

  assign out0_valid = (occ[0] != 2'd0);
  assign out1_valid = (occ[1] != 2'd0);
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

  always_comb begin
    push         = '0;
    push[in_sel] = in_valid && in_ready;
    pop          = '0;
    pop[0]       = out0_valid && out0_ready;
    pop[1]       = out1_valid && out1_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int k = 0; k < 2; k++) begin
        occ[k]    <= '0;
        cnt[k]    <= '0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= in_data;
          wr_ptr[k]         <= ~wr_ptr[k];
        end
        if (pop[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
          cnt[k]    <= cnt[k] + CNTW'(1);
        end
        // Simultaneous push and pop cancel out, leaving occupancy unchanged.
        occ[k] <= occ[k] + {1'b0, push[k]} - {1'b0, pop[k]};
      end
    end
  end

endmodule

// File: doc/stream_demux2.md
STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the payload width in bits.
REQ-002 SHALL have parameter CNTW, default 16, the width of each delivered-beat counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_data  input  WIDTH  payload of the input beat.
REQ-006 SHALL have port in_sel  input  1  destination of the beat: 0 selects output 0, 1 selects output 1.
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  block can accept the beat on in_data/in_sel this cycle.
REQ-009 SHALL have ports out0_data / out1_data  output  WIDTH  head-of-queue payload per output.
REQ-010 SHALL have ports out0_valid / out1_valid  output  1  head-of-queue valid per output.
REQ-011 SHALL have ports out0_ready / out1_ready  input  1  downstream accepts the head beat.
REQ-012 SHALL have ports cnt0 / cnt1  output  CNTW  count of beats delivered on each output.

Function
REQ-013 SHALL treat an input transfer as in_valid and in_ready both high on a rising edge, and an output-k transfer as outk_valid and outk_ready both high.
REQ-014 SHALL give each output its own 2-entry FIFO (storage, read pointer, write pointer, occupancy 0..2).
REQ-015 SHALL drive in_ready high exactly when reset is low and the occupancy of the FIFO selected by in_sel is below 2.
REQ-016 SHALL keep in_ready independent of out0_ready/out1_ready, so no combinational path runs from output ready to input ready.
REQ-017 SHALL push each input transfer only into the FIFO selected by in_sel, leaving the other FIFO unchanged.
REQ-018 SHALL drive outk_valid high exactly when FIFO k occupancy is nonzero.
REQ-019 SHALL drive outk_data from the FIFO k head entry, held stable while outk_valid is high and outk_ready is low.
REQ-020 SHALL make a beat accepted in cycle N visible on its output no earlier than cycle N+1, with no combinational in-to-out path.
REQ-021 SHALL preserve acceptance order within each output; no ordering is required between the two outputs.
REQ-022 SHALL handle a push and a pop on the same FIFO in one cycle by moving both pointers, leaving occupancy unchanged (only possible at occupancy 1).
REQ-023 SHALL let both FIFOs pop in the same cycle independently, and let a push to one FIFO coincide with a pop of the other.
REQ-024 SHALL advance pointers modulo 2.
REQ-025 SHALL never let occupancy exceed 2 or fall below 0.
REQ-026 SHALL ignore in_data and in_sel whenever in_valid is low.
REQ-027 SHALL increment cntk by 1 on every output-k transfer and wrap from 2^CNTW-1 to 0 with no saturation or flag.
REQ-028 SHALL leave a stalled input (in_valid high, in_ready low) free to change in_sel; in_ready then reflects the newly selected FIFO in the same cycle.

Reset
REQ-029 SHALL, on a rising edge with reset high, clear both occupancies, all pointers, cnt0 and cnt1, and all storage to 0.
REQ-030 SHALL therefore hold out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0 after that edge.
REQ-031 SHALL hold in_ready low while reset is high.
REQ-032 SHALL give reset priority over any same-cycle push or pop, discarding in-flight FIFO contents.

Verification
REQ-033 SHALL pass the routing check: after reset, push A5A5A5A5 with sel=0, then 5A5A5A5A with sel=1, outputs ready=0 -> out0_data=A5A5A5A5, out1_data=5A5A5A5A, both valid, each valid first seen one cycle after its push.
REQ-034 SHALL pass the backpressure check: push 1, 2, 3 with sel=0 and out0_ready=0 -> beats 1 and 2 accepted, in_ready=0 on the third, out1 untouched; switching to sel=1 raises in_ready the same cycle.
REQ-035 SHALL pass the ordering check: with out0 at occupancy 1, push with sel=0 and pop out0 in the same cycle -> occupancy stays 1, order 1, 2, 3 delivered, cnt0=3.
REQ-036 SHALL pass the counter-wrap check: with CNTW=4, deliver 17 beats on out1 -> cnt1=1, cnt0=0.
REQ-037 SHALL pass the mid-operation reset check: both FIFOs full, reset high for one cycle -> next cycle both valids 0, both counters 0; in_ready low during reset and high after.
REQ-038 SHALL pass the data-stability check: out0_valid high with out0_ready low for 5 cycles while in_data toggles -> out0_data constant.
